riscv_muldiv: RTL and testbench

- Parametrised multi-cycle RV32M/RV64M multiply/divide unit; sits beside the single-cycle ALU in the EX stage.
- Accepts one operation through a valid/ready handshake and returns a registered result through a valid/ready handshake.
- Supports stall from downstream and kill from a pipeline flush.
- Division is iterative radix-2 restoring. Multiply is iterative shift-add, or single-cycle when FAST_MUL=1.

---
 rtl/riscv_muldiv_if.sv | 26 ++
 rtl/riscv_muldiv.sv | 178 +++++++++++++++++
 tb/tb_riscv_muldiv.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the EX-stage issue logic and the
// multiply/divide unit. Signal names follow the unit's port list.
interface riscv_muldiv_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_md_op;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_kill;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid, i_md_op, i_rs1, i_rs2, i_kill, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_md_op, i_rs1, i_rs2, i_kill, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/riscv_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: sign-magnitude shift-add
// multiplier and radix-2 restoring divider sharing one accumulator pair.
module riscv_muldiv #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  riscv_muldiv_if.slave         bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd3;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN:0]   acc_q, acc_d;   // remainder (div) / high product (mul)
  logic [XLEN-1:0] lo_q, lo_d;     // quotient (div) / low product (mul)
  logic [XLEN-1:0] b_q, b_d;       // divisor (div) / multiplicand (mul)
  logic            neg_q, neg_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            valid_q, valid_d;

  // Request decode, valid only at the accept edge.
  logic            req_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res, fast_res;
  logic signed [2*XLEN-1:0] fast_prod;

  assign req_div  = bus.i_md_op[2];
  assign a_signed = req_div ? ~bus.i_md_op[0] : (bus.i_md_op != OP_MULHU);
  assign b_signed = req_div ? ~bus.i_md_op[0] : ~bus.i_md_op[1];
  assign sa       = a_signed & bus.i_rs1[XLEN-1];
  assign sb       = b_signed & bus.i_rs2[XLEN-1];
  assign a_abs    = sa ? -bus.i_rs1 : bus.i_rs1;
  assign b_abs    = sb ? -bus.i_rs2 : bus.i_rs2;

  assign div_zero = req_div && (bus.i_rs2 == '0);
  assign div_ovf  = req_div && !bus.i_md_op[0] &&
                    (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_rs2 == '1);
  // Remainder ops (funct3 bit 1 set) return rs1 on /0 and zero on overflow.
  assign special_res = div_zero ? (bus.i_md_op[1] ? bus.i_rs1 : '1)
                                : (bus.i_md_op[1] ? '0 : bus.i_rs1);

  assign fast_prod = $signed({{XLEN{sa}}, bus.i_rs1}) * $signed({{XLEN{sb}}, bus.i_rs2});
  assign fast_res  = (bus.i_md_op == OP_MUL) ? fast_prod[XLEN-1:0]
                                             : fast_prod[2*XLEN-1:XLEN];

  // One iteration of each algorithm.
  logic [XLEN:0]   mul_t;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;

  assign mul_t     = lo_q[0] ? (acc_q + {1'b0, b_q}) : acc_q;
  assign div_shift = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};

  // Sign fix-up and high/low selection.
  logic [2*XLEN-1:0] prod_mag, prod_s;
  logic [XLEN-1:0]   div_mag, fix_res;

  assign prod_mag = {acc_q[XLEN-1:0], lo_q};
  assign prod_s   = neg_q ? -prod_mag : prod_mag;
  assign div_mag  = op_q[1] ? acc_q[XLEN-1:0] : lo_q;
  assign fix_res  = op_q[2] ? (neg_q ? -div_mag : div_mag)
                  : (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  // NOTE: every _d starts from its _q so no path leaves a variable unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    b_d     = b_q;
    neg_d   = neg_q;
    res_d   = res_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          op_d  = bus.i_md_op;
          neg_d = (req_div && bus.i_md_op[1]) ? sa : (sa ^ sb);
          cnt_d = CW'(XLEN-1);
          acc_d = '0;
          lo_d  = req_div ? a_abs : b_abs;
          b_d   = req_div ? b_abs : a_abs;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = DONE;
          end else if (FAST_MUL != 0 && !req_div) begin
            res_d   = fast_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          if (!div_diff[XLEN+1]) begin
            acc_d = div_diff[XLEN:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = div_shift;
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, mul_t[XLEN:1]};
          lo_d  = {mul_t[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: begin
        // First DONE cycle raises o_valid; the result is already in res_q.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.i_kill && state_q != IDLE) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = res_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench: an iterative unit (dut 0) and a FAST_MUL unit (dut 1);
// the driver queues expected results, a negedge monitor pops and checks them.
module tb_riscv_muldiv;

  localparam int XLEN = 32;
  localparam int LAT_ITER = XLEN + 2;
  localparam int LAT_ONE  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready_in = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  riscv_muldiv_if #(.XLEN(XLEN)) s_if ();
  riscv_muldiv_if #(.XLEN(XLEN)) f_if ();

  riscv_muldiv #(.XLEN(XLEN), .FAST_MUL(0)) u_slow (
    .i_clk (clk),
    .i_rstn(rst_n),
    .bus   (s_if.slave)
  );

  riscv_muldiv #(.XLEN(XLEN), .FAST_MUL(1)) u_fast (
    .i_clk (clk),
    .i_rstn(rst_n),
    .bus   (f_if.slave)
  );

  assign s_if.i_ready = ready_in;
  assign f_if.i_ready = ready_in;

  typedef struct {
    int          dut;
    logic [31:0] val;
    int          acc_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: pop on each rising o_valid, then hold the value while o_valid stays.
  logic [1:0]  v, pv;
  logic [1:0]  rdy;
  logic [31:0] res [2];
  logic [31:0] held [2];

  assign v   = {f_if.o_valid, s_if.o_valid};
  assign rdy = {f_if.o_ready, s_if.o_ready};
  assign res[0] = s_if.o_result;
  assign res[1] = f_if.o_result;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv = 2'b00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (v[d] && !pv[d]) begin
          if (sbq.size() == 0) begin
            fail_now($sformatf("unexpected_valid_dut%0d", d));
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check({e.name, "_dut"}, 64'(d), 64'(e.dut));
            check(e.name, {32'h0, res[d]}, {32'h0, e.val});
            check({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
            held[d] = e.val;
          end
        end else if (v[d]) begin
          check($sformatf("hold_result_dut%0d", d), {32'h0, res[d]}, {32'h0, held[d]});
        end
        if (v[d]) check($sformatf("ready_low_in_done_dut%0d", d), 64'(rdy[d]), 64'd0);
        pv[d] = v[d];
      end
    end
  end

  task automatic issue(input int dut, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit exp_en, input logic [31:0] expv,
                       input int lat, input string name);
    int budget = 0;
    while (!(dut == 1 ? f_if.o_ready : s_if.o_ready) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) fail_now({name, "_ready_wait"});
    if (dut == 1) begin
      f_if.i_valid = 1'b1; f_if.i_md_op = op; f_if.i_rs1 = a; f_if.i_rs2 = b;
    end else begin
      s_if.i_valid = 1'b1; s_if.i_md_op = op; s_if.i_rs1 = a; s_if.i_rs2 = b;
    end
    if (exp_en) sbq.push_back('{dut, expv, cyc + 1, lat, name});
    @(posedge clk);
    #1;
    s_if.i_valid = 1'b0;
    f_if.i_valid = 1'b0;
    // Scramble operands after accept; the unit must have latched them.
    s_if.i_rs1 = 32'hDEAD_BEEF; s_if.i_rs2 = 32'h0BAD_F00D;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while ((sbq.size() != 0 || s_if.o_busy || f_if.o_busy) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 500) fail_now({name, "_drain"});
  endtask

  initial begin
    s_if.i_valid = 1'b0; s_if.i_md_op = 3'd0; s_if.i_rs1 = '0; s_if.i_rs2 = '0; s_if.i_kill = 1'b0;
    f_if.i_valid = 1'b0; f_if.i_md_op = 3'd0; f_if.i_rs1 = '0; f_if.i_rs2 = '0; f_if.i_kill = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready",  64'(s_if.o_ready),  64'd1);
    check("reset_valid",  64'(s_if.o_valid),  64'd0);
    check("reset_busy",   64'(s_if.o_busy),   64'd0);
    check("reset_result", {32'h0, s_if.o_result}, 64'h0);

    // Iterative divide / multiply.
    issue(0, 3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 1, 32'hFFFF_FFFA, LAT_ITER, "div_m20_3");
    issue(0, 3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 1, 32'hFFFF_FFFE, LAT_ITER, "rem_m20_3");
    issue(0, 3'd5, 32'hFFFF_FFEC, 32'h0000_0003, 1, 32'h5555_554E, LAT_ITER, "divu_big_3");
    issue(0, 3'd7, 32'hFFFF_FFEC, 32'h0000_0003, 1, 32'h0000_0002, LAT_ITER, "remu_big_3");
    issue(0, 3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, LAT_ITER, "div_7_m2");
    issue(0, 3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 1, 32'h0000_0001, LAT_ITER, "rem_7_m2");
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, LAT_ITER, "rem_m7_2");
    issue(0, 3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'hFFFF_FFFF, LAT_ITER, "divu_max_1");
    issue(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, LAT_ITER, "mulh_min_min");
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, LAT_ITER, "mulhsu_m1_max");
    issue(0, 3'd0, 32'h8000_0000, 32'h8000_0000, 1, 32'h0000_0000, LAT_ITER, "mul_min_min");
    issue(0, 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, LAT_ITER, "mul_7_m3");
    issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, LAT_ITER, "mulhu_max_max");
    issue(0, 3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 32'h3FFF_FFFF, LAT_ITER, "mulh_maxpos");

    // Special cases bypass CALC.
    issue(0, 3'd5, 32'h0000_5678, 32'h0000_0000, 1, 32'hFFFF_FFFF, LAT_ONE, "divu_by0");
    issue(0, 3'd7, 32'h0000_1234, 32'h0000_0000, 1, 32'h0000_1234, LAT_ONE, "remu_by0");
    issue(0, 3'd4, 32'hFFFF_FFF0, 32'h0000_0000, 1, 32'hFFFF_FFFF, LAT_ONE, "div_by0");
    issue(0, 3'd6, 32'hFFFF_FFF0, 32'h0000_0000, 1, 32'hFFFF_FFF0, LAT_ONE, "rem_by0");
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, LAT_ONE, "div_ovf");
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, LAT_ONE, "rem_ovf");
    drain("iter_phase");

    // Fast multiplier.
    issue(1, 3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, LAT_ONE, "fast_mulh");
    issue(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, LAT_ONE, "fast_mulhsu");
    issue(1, 3'd0, 32'h8000_0000, 32'h8000_0000, 1, 32'h0000_0000, LAT_ONE, "fast_mul");
    issue(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, LAT_ONE, "fast_mulhu");
    issue(1, 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, LAT_ONE, "fast_mul_neg");
    issue(1, 3'd5, 32'h0000_0064, 32'h0000_0007, 1, 32'h0000_000E, LAT_ITER, "fast_divu_iter");
    drain("fast_phase");

    // Back-pressure: result held in DONE until i_ready.
    ready_in = 1'b0;
    issue(0, 3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 1, 32'hFFFF_FFFA, LAT_ITER, "div_stalled");
    begin
      int budget = 0;
      while (!s_if.o_valid && budget < 100) begin @(negedge clk); budget++; end
      if (budget >= 100) fail_now("stall_valid_wait");
    end
    repeat (5) @(negedge clk);
    check("stall_still_valid", 64'(s_if.o_valid), 64'd1);
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid_low", 64'(s_if.o_valid), 64'd0);
    check("release_ready_high", 64'(s_if.o_ready), 64'd1);
    issue(0, 3'd7, 32'h0000_0064, 32'h0000_0007, 1, 32'h0000_0002, LAT_ITER, "remu_after_release");
    drain("stall_phase");

    // Kill during CALC.
    issue(0, 3'd4, 32'h1234_5678, 32'h0000_0013, 0, '0, 0, "div_killed");
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("busy_before_kill", 64'(s_if.o_busy), 64'd1);
    s_if.i_kill = 1'b1;
    @(posedge clk);
    #1;
    s_if.i_kill = 1'b0;
    check("kill_busy", 64'(s_if.o_busy), 64'd0);
    check("kill_ready", 64'(s_if.o_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("kill_no_valid", 64'(s_if.o_valid), 64'd0);

    // Asynchronous reset during CALC.
    issue(0, 3'd5, 32'hFFFF_0000, 32'h0000_0011, 0, '0, 0, "divu_reset");
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready",  64'(s_if.o_ready), 64'd1);
    check("rst_mid_busy",   64'(s_if.o_busy),  64'd0);
    check("rst_mid_valid",  64'(s_if.o_valid), 64'd0);
    check("rst_mid_result", {32'h0, s_if.o_result}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_valid", 64'(s_if.o_valid), 64'd0);

    issue(0, 3'd5, 32'h0000_0064, 32'h0000_0007, 1, 32'h0000_000E, LAT_ITER, "divu_100_7");
    drain("final_phase");
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
